// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with imem valid/ack handshake, halt and fault traps.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run_en,
  input  logic             i_halt_req,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  input  logic             i_imem_err,
  output logic             o_ir_we,
  output logic             o_rf_we,
  output logic             o_pc_we,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExec    = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5,
    StFault   = 3'd6,
    StIllegal = 3'd7
  } state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          r_state;
  state_e          w_state_d;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_d;
  logic            w_imem_req;
  logic            w_ir_we;
  logic            w_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_d;
      r_to_cnt <= w_to_cnt_d;
    end
  end

  // Timeout counter only advances while waiting in FETCH; every other path clears it.
  always_comb begin
    w_state_d  = r_state;
    w_to_cnt_d = '0;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_wb       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_run_en) w_state_d = StFetch;
      end
      StFetch: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          if (i_imem_err) begin
            w_state_d = StFault;
          end else begin
            w_ir_we   = 1'b1;
            w_state_d = StDecode;
          end
        end else if (r_to_cnt == ToLast) begin
          w_state_d = StFault;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
        end
      end
      StDecode: w_state_d = i_halt_req ? StHalt : StExec;
      StExec:   w_state_d = StWb;
      StWb: begin
        w_wb      = 1'b1;
        w_state_d = i_run_en ? StFetch : StIdle;
      end
      StHalt:   w_state_d = StHalt;
      StFault:  w_state_d = StFault;
      default:  w_state_d = StIdle;
    endcase
  end

  assign o_imem_req = w_imem_req & ~rst;
  assign o_ir_we    = w_ir_we & ~rst;
  assign o_rf_we    = w_wb & ~rst;
  assign o_pc_we    = w_wb & ~rst;
  assign o_state    = r_state;
  assign o_halted   = (r_state == StHalt);
  assign o_fault    = (r_state == StFault);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_active;

  assign w_active = (r_state == StFetch) || (r_state == StDecode) ||
                    (r_state == StExec)  || (r_state == StWb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_active) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_wb)     r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  assign o_cycle_cnt   = '0;
  assign o_instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: per-cycle comparison against an instruction-progress model,
// plus directed scenarios with literal expectations.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        run_en;
  logic        halt_req;
  logic        imem_req;
  logic        imem_ack;
  logic        imem_err;
  logic        ir_we;
  logic        rf_we;
  logic        pc_we;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  core_seq_ctrl #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (5),
    .CNT_W         (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_run_en     (run_en),
    .i_halt_req   (halt_req),
    .o_imem_req   (imem_req),
    .i_imem_ack   (imem_ack),
    .i_imem_err   (imem_err),
    .o_ir_we      (ir_we),
    .o_rf_we      (rf_we),
    .o_pc_we      (pc_we),
    .o_state      (state),
    .o_halted     (halted),
    .o_fault      (fault),
    .o_cycle_cnt  (cycle_cnt),
    .o_instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 halted, 3 faulted; phase counts steps within an instruction.
  int          m_mode  = 0;
  int          m_phase = 0;
  int          m_waits = 0;
  logic [31:0] m_cyc   = 0;
  logic [31:0] m_ret   = 0;

  always @(negedge clk) begin
    logic run;
    run = (m_mode == 1);
    if (en) begin
      chk("state", {29'd0, state},
          m_mode == 0 ? 32'd0 : m_mode == 2 ? 32'd5 : m_mode == 3 ? 32'd6 : 32'(1 + m_phase));
      chk("imem_req", {31'd0, imem_req}, {31'd0, !rst && run && m_phase == 0});
      chk("ir_we", {31'd0, ir_we},
          {31'd0, !rst && run && m_phase == 0 && imem_ack && !imem_err});
      chk("rf_we", {31'd0, rf_we}, {31'd0, !rst && run && m_phase == 3});
      chk("pc_we", {31'd0, pc_we}, {31'd0, !rst && run && m_phase == 3});
      chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
      chk("fault", {31'd0, fault}, {31'd0, m_mode == 3});
`ifdef SEQ_PERF_CNT_EN
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instret_cnt", instret_cnt, m_ret);
`else
      chk("cycle_cnt", cycle_cnt, 32'd0);
      chk("instret_cnt", instret_cnt, 32'd0);
`endif
    end
    if (rst) begin
      m_mode = 0; m_phase = 0; m_waits = 0; m_cyc = 0; m_ret = 0;
    end else if (m_mode == 0) begin
      if (run_en) begin m_mode = 1; m_phase = 0; m_waits = 0; end
    end else if (m_mode == 1) begin
      m_cyc = m_cyc + 1;
      case (m_phase)
        0: begin
          if (imem_ack) begin
            if (imem_err) m_mode = 3;
            else m_phase = 1;
          end else begin
            m_waits++;
            if (m_waits == 16) m_mode = 3;
          end
        end
        1: if (halt_req) m_mode = 2; else m_phase = 2;
        2: m_phase = 3;
        default: begin
          m_ret = m_ret + 1;
          m_phase = 0; m_waits = 0;
          if (!run_en) m_mode = 0;
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at "cycle 0": DUT in IDLE just after reset, inputs idle.
  task automatic do_reset();
    rst = 1'b1; run_en = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
    cyc();
    en = 1'b1;

    // Zero-wait stream: states 1,2,3,4 repeat.
    do_reset();
    chk("t1_reset_state", {29'd0, state}, 32'd0);
    chk("t1_reset_halted", {31'd0, halted}, 32'd0);
    chk("t1_reset_fault", {31'd0, fault}, 32'd0);
    run_en = 1'b1; imem_ack = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("t1_state", {29'd0, state}, 32'(1 + ((k - 1) % 4)));
      chk("t1_ir_we", {31'd0, ir_we}, {31'd0, (k % 4) == 1});
      chk("t1_pc_we", {31'd0, pc_we}, {31'd0, (k % 4) == 0});
    end

    // Three wait cycles on imem.
    do_reset();
    run_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("t2_req_wait", {31'd0, imem_req}, 32'd1);
      chk("t2_no_ir_we", {31'd0, ir_we}, 32'd0);
    end
    cyc();
    imem_ack = 1'b1;
    #1;
    chk("t2_req_ack", {31'd0, imem_req}, 32'd1);
    chk("t2_ir_we", {31'd0, ir_we}, 32'd1);
    cyc(); imem_ack = 1'b0;
    chk("t2_decode", {29'd0, state}, 32'd2);
    cyc();
    cyc(); run_en = 1'b0;
    chk("t2_pc_we_c7", {31'd0, pc_we}, 32'd1);
    cyc();
    chk("t2_idle", {29'd0, state}, 32'd0);

    // Fetch timeout.
    do_reset();
    run_en = 1'b1;
    for (int k = 1; k <= 16; k++) cyc();
    chk("t3_last_fetch", {29'd0, state}, 32'd1);
    cyc();
    chk("t3_fault_state", {29'd0, state}, 32'd6);
    chk("t3_fault", {31'd0, fault}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      run_en = k[0]; imem_ack = 1'b1;
      cyc();
      chk("t3_fault_hold", {29'd0, state}, 32'd6);
    end

    // Halt in DECODE.
    do_reset();
    run_en = 1'b1; imem_ack = 1'b1;
    cyc();
    cyc(); halt_req = 1'b1;
    cyc(); halt_req = 1'b0;
    chk("t4_halt_state", {29'd0, state}, 32'd5);
    chk("t4_halted", {31'd0, halted}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      run_en = ~run_en;
      cyc();
      chk("t4_halt_hold", {29'd0, state}, 32'd5);
    end
    rst = 1'b1;
    cyc(); rst = 1'b0; run_en = 1'b0;
    chk("t4_rst_state", {29'd0, state}, 32'd0);
    chk("t4_rst_halted", {31'd0, halted}, 32'd0);

    // Error beats ack.
    do_reset();
    run_en = 1'b1;
    cyc(); imem_ack = 1'b1; imem_err = 1'b1;
    #1;
    chk("t5_err_no_ir_we", {31'd0, ir_we}, 32'd0);
    cyc(); imem_ack = 1'b0; imem_err = 1'b0;
    chk("t5_err_fault", {29'd0, state}, 32'd6);

    // Reset during EXEC aborts without WB strobes.
    do_reset();
    run_en = 1'b1; imem_ack = 1'b1;
    cyc(); cyc(); cyc();
    chk("t5_exec", {29'd0, state}, 32'd3);
    rst = 1'b1;
    cyc();
    chk("t5_abort_state", {29'd0, state}, 32'd0);
    chk("t5_abort_pc_we", {31'd0, pc_we}, 32'd0);
    chk("t5_abort_rf_we", {31'd0, rf_we}, 32'd0);
    rst = 1'b0; run_en = 1'b0; imem_ack = 1'b0;
    cyc();

    // Ten zero-wait instructions.
    do_reset();
    run_en = 1'b1; imem_ack = 1'b1;
    for (int k = 1; k <= 40; k++) cyc();
    run_en = 1'b0;
    cyc();
    chk("t6_idle", {29'd0, state}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("t6_cycle_cnt", cycle_cnt, 32'd40);
    chk("t6_instret_cnt", instret_cnt, 32'd10);
`else
    chk("t6_cycle_cnt", cycle_cnt, 32'd0);
    chk("t6_instret_cnt", instret_cnt, 32'd0);
`endif
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
